// File: rtl/arbitro_comparador_pkg.sv
// arbitro_comparador_pkg: shared operand width and FSM state encoding
package arbitro_comparador_pkg;
  localparam int W = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/arbitro_comparador_nucleo.sv
// comparador_nucleo: registered unsigned magnitude compare of two operands
module comparador_nucleo
  import arbitro_comparador_pkg::*;
(
  input  logic         clk,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_gt,
  output logic         o_lt
);
  always_ff @(posedge clk) begin
    o_gt <= i_a > i_b;
    o_lt <= i_a < i_b;
  end
endmodule

// File: rtl/arbitro_comparador.sv
// arbitro_comparador: round-robin arbiter sharing one registered comparator between two requesters
module arbitro_comparador
  import arbitro_comparador_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         valid0,
  output logic         valid1,
  output logic         gt,
  output logic         lt,
  output logic         busy
);
  logic [1:0]   r_state;
  logic         r_last;
  logic         r_owner;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         w_cgt;
  logic         w_clt;
  logic         w_pick1;
  // r_last holds the most recent winner; requester 1 wins a tie only if 0 won last
  assign w_pick1 = req1 & (~req0 | ~r_last);
  assign busy    = r_state != S_IDLE;
  comparador_nucleo u_nucleo (
    .clk (clk),
    .i_a (r_a),
    .i_b (r_b),
    .o_gt(w_cgt),
    .o_lt(w_clt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      valid0  <= 1'b0;
      valid1  <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      case (r_state)
        S_IDLE: if (req0 | req1) begin
          r_a     <= w_pick1 ? a1 : a0;
          r_b     <= w_pick1 ? b1 : b0;
          r_owner <= w_pick1;
          r_last  <= w_pick1;
          gnt0    <= ~w_pick1;
          gnt1    <= w_pick1;
          r_state <= S_CMP;
        end
        S_CMP: r_state <= S_DONE;
        S_DONE: begin
          gt      <= w_cgt;
          lt      <= w_clt;
          valid0  <= ~r_owner;
          valid1  <= r_owner;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_arbitro_comparador.sv
// tb_arbitro_comparador: directed checks of grant order, latency, results and reset behaviour
module tb_arbitro_comparador;
  logic clk = 1'b0, rst = 1'b1, req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic gnt0, gnt1, valid0, valid1, gt, lt, busy;
  logic m_gt = 1'b0, m_lt = 1'b0;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  arbitro_comparador dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .valid0(valid0), .valid1(valid1),
    .gt(gt), .lt(lt), .busy(busy)
  );
  // expected vector layout: {gnt0, gnt1, valid0, valid1, gt, lt, busy}
  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {gnt0, gnt1, valid0, valid1, gt, lt, busy};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic single(input string tag, input bit who, input logic [7:0] a, b, input bit egt, elt);
    if (!who) begin req0 = 1'b1; a0 = a; b0 = b; end
    else begin req1 = 1'b1; a1 = a; b1 = b; end
    @(negedge clk);
    chk({tag, "_gnt"}, {~who, who, 2'b00, m_gt, m_lt, 1'b1});
    req0 = 1'b0;
    req1 = 1'b0;
    if (!who) begin a0 = 8'd0; b0 = ~b; end
    else begin a1 = 8'd0; b1 = ~b; end
    @(negedge clk);
    chk({tag, "_cmp"}, {4'b0000, m_gt, m_lt, 1'b1});
    @(negedge clk);
    m_gt = egt;
    m_lt = elt;
    chk({tag, "_valid"}, {2'b00, ~who, who, egt, elt, 1'b0});
    @(negedge clk);
    chk({tag, "_hold"}, {4'b0000, m_gt, m_lt, 1'b0});
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset", 7'b0000_00_0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle", 7'b0000_00_0);
    single("gt200_100", 1'b0, 8'd200, 8'd100, 1'b1, 1'b0);
    single("eq55", 1'b1, 8'd55, 8'd55, 1'b0, 1'b0);
    single("lt3_250", 1'b1, 8'd3, 8'd250, 1'b0, 1'b1);
    single("stable9_8", 1'b0, 8'd9, 8'd8, 1'b1, 1'b0);
    single("ext255_0", 1'b0, 8'd255, 8'd0, 1'b1, 1'b0);
    single("ext0_255", 1'b1, 8'd0, 8'd255, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("reset2", 7'b0000_00_0);
    rst = 1'b0;
    req0 = 1'b1; a0 = 8'd10; b0 = 8'd20;
    req1 = 1'b1; a1 = 8'd30; b1 = 8'd5;
    @(negedge clk); chk("tie_gnt0", 7'b1000_00_1);
    @(negedge clk); chk("tie_cmp0", 7'b0000_00_1);
    @(negedge clk); chk("tie_valid0", 7'b0010_01_0);
    @(negedge clk); chk("tie_gnt1", 7'b0100_01_1);
    @(negedge clk); chk("tie_cmp1", 7'b0000_01_1);
    @(negedge clk); chk("tie_valid1", 7'b0001_10_0);
    @(negedge clk); chk("tie_gnt0b", 7'b1000_10_1);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk); chk("tie_cmp0b", 7'b0000_10_1);
    @(negedge clk); chk("tie_valid0b", 7'b0010_01_0);
    req0 = 1'b1; a0 = 8'd255; b0 = 8'd0;
    @(negedge clk); chk("mid_gnt0", 7'b1000_01_1);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk); chk("mid_reset", 7'b0000_00_0);
    rst = 1'b0;
    @(negedge clk); chk("mid_novalid", 7'b0000_00_0);
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk); chk("post_tie_gnt0", 7'b1000_00_1);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk); chk("post_cmp", 7'b0000_00_1);
    @(negedge clk); chk("post_valid0", 7'b0010_10_0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/arbitro_comparador.md
ARBITRO_COMPARADOR -- requirements
Module: arbitro_comparador

Interface
REQ-001 SHALL have ports, clock and reset first:
 clk  input  1  rising-edge clock, sole clock domain
 rst  input  1  synchronous, active-high reset
 req0  input  1  requester 0 compare request, level
 a0  input  8  requester 0 operand A, unsigned
 b0  input  8  requester 0 operand B, unsigned
 req1  input  1  requester 1 compare request, level
 a1  input  8  requester 1 operand A, unsigned
 b1  input  8  requester 1 operand B, unsigned
 gnt0  output  1  one-cycle pulse, requester 0 operands captured
 gnt1  output  1  one-cycle pulse, requester 1 operands captured
 valid0  output  1  one-cycle pulse, result for requester 0 on gt/lt
 valid1  output  1  one-cycle pulse, result for requester 1 on gt/lt
 gt  output  1  1 when captured A > B
 lt  output  1  1 when captured A < B
 busy  output  1  1 whenever FSM is not IDLE
REQ-002 SHALL have parameters: none; operand width fixed at 8 bits.

Function
REQ-003 SHALL implement a three-state FSM: IDLE, CMP, DONE.
REQ-004 IDLE: if any req is high at a clock edge, SHALL capture the winner's operands, pulse that requester's gnt for the next cycle, and go to CMP; otherwise stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: with a single req, grant it; with both high, grant the requester not granted most recently.
REQ-006 CMP SHALL register the unsigned compare of the captured operands and go to DONE unconditionally.
REQ-007 DONE SHALL load gt/lt from the registered compare, pulse the owner's valid for one cycle, and return to IDLE.
REQ-008 Latency: req sampled at the edge ending cycle n. gnt high in cycle n+1. valid and new gt/lt visible in cycle n+3.
REQ-009 Throughput SHALL be one compare per 3 cycles; back-to-back grants SHALL be possible when req is high in the valid cycle.
REQ-010 gt and lt SHALL NOT both be 1. On equality both SHALL be 0.
REQ-011 gt and lt SHALL hold their last value between results.
REQ-012 Operands SHALL be captured only at the grant edge; operand changes after gnt SHALL NOT affect the result.
REQ-013 A requester SHALL drop req after seeing gnt. A req still high when the FSM is in IDLE SHALL be treated as a new request.
REQ-014 Requests arriving while busy=1 SHALL be ignored until IDLE and SHALL NOT be lost if held.
REQ-015 busy SHALL be 1 in CMP and DONE, and 0 in IDLE.
REQ-016 At most one of gnt0/gnt1 and at most one of valid0/valid1 SHALL be high in any cycle.

Reset
REQ-017 rst=1 at an edge SHALL force: IDLE, all gnt/valid=0, gt=lt=0, busy=0, and the round-robin pointer set so requester 0 wins the first tie.
REQ-018 Reset in CMP or DONE SHALL abandon the operation with no valid pulse; rst has priority over all requests.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding constants and the operand-width constant (8).
REQ-020 The registered compare SHALL be one sub-module, comparador_nucleo (8-bit A, B in; registered gt, lt out; clk, no reset needed), instantiated once.

Verification
REQ-021 Single request: req0=1, a0=200, b0=100 -> gnt0 in cycle n+1, valid0 in cycle n+3 with gt=1, lt=0.
REQ-022 Equality and less-than: req1 with a1=b1=55 -> valid1, gt=lt=0. Then req1 with a1=3, b1=250 -> lt=1, gt=0.
REQ-023 Tie from reset: req0 and req1 high together (a0=10,b0=20; a1=30,b1=5), held high -> order gnt0, gnt1, gnt0, ... Results lt=1 (valid0) then gt=1 (valid1). No dual gnt/valid.
REQ-024 Operand stability: after gnt0, change a0 from 9 to 0 with b0=8 -> result still gt=1.
REQ-025 Reset mid-op: assert rst in the CMP cycle -> no valid pulse, busy=0, gt=lt=0 next cycle. Next tie grants requester 0.
REQ-026 Extreme values: a=255, b=0 -> gt=1. a=0, b=255 -> lt=1. Check no sign/overflow error.
